// File: rtl/act_row_scheduler.sv
// Row-streaming activation scheduler: reads ROWS rows from a source buffer, applies
// bypass/ReLU/leaky-ReLU per element and hands rows out through a 2-entry FIFO.
module act_row_scheduler #(
  parameter int ROWS = 10,
  parameter int COLS = 10,
  parameter int W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [$clog2(ROWS)-1:0] rd_addr,
  input  logic [COLS*W-1:0]       rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(ROWS)-1:0] out_row,
  output logic [COLS*W-1:0]       out_data
);

  localparam int AW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS + 1);
  localparam logic [CW-1:0] ROWS_C = CW'(ROWS);
  localparam logic [CW-1:0] LAST_C = CW'(ROWS - 1);
  localparam logic [1:0] M_RELU  = 2'd1;
  localparam logic [1:0] M_LEAKY = 2'd2;
  localparam logic signed [W+3:0] LEAKY_K = 13;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [1:0]        mode_q;
  logic [CW-1:0]     issued;
  logic [CW-1:0]     accepted;
  logic              start_acc;
  logic              push;
  logic              pop;
  logic [2:0]        occ;

  logic              vld_p0;
  logic [AW-1:0]     row_p0;
  logic [COLS*W-1:0] act_p0;

  logic [COLS*W-1:0] fifo_data [2];
  logic [AW-1:0]     fifo_row  [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_cnt;

  // Leaky slope 13/128 with floor rounding; the W+4 product cannot overflow for |x| <= 2^(W-1).
  function automatic logic signed [W-1:0] act_elem(input logic signed [W-1:0] x,
                                                  input logic [1:0] m);
    logic signed [W+3:0] prod;
    logic signed [W+3:0] shf;
    prod = {{4{x[W-1]}}, x};
    prod = prod * LEAKY_K;
    shf  = prod >>> 7;
    act_elem = x;
    if (x[W-1]) begin
      if (m == M_RELU) begin
        act_elem = '0;
      end else if (m == M_LEAKY) begin
        act_elem = shf[W-1:0];
      end
    end
  endfunction

  assign start_acc = (state == S_IDLE) && start;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FINISH);
  assign out_valid = (state == S_RUN) && (fifo_cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = vld_p0;

  // Slots committed after this edge; crediting the pop keeps one row per cycle flowing.
  assign occ     = {1'b0, fifo_cnt} + {2'b00, vld_p0} - {2'b00, pop};
  assign rd_en   = (state == S_RUN) && (issued < ROWS_C) && (occ < 3'd2);
  assign rd_addr = issued[AW-1:0];

  assign out_row  = out_valid ? fifo_row[rd_ptr]  : '0;
  assign out_data = out_valid ? fifo_data[rd_ptr] : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_RUN;
      S_RUN:    if (pop && (accepted == LAST_C)) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      mode_q   <= '0;
      issued   <= '0;
      accepted <= '0;
      vld_p0   <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        mode_q   <= mode;
        issued   <= '0;
        accepted <= '0;
      end else begin
        if (rd_en) issued   <= issued + CW'(1);
        if (pop)   accepted <= accepted + CW'(1);
      end
      vld_p0 <= rd_en;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // p0: read in flight; rd_data returns alongside vld_p0 and is activated combinationally.
  always_comb begin
    act_p0 = '0;
    for (int j = 0; j < COLS; j++) begin
      act_p0[j*W +: W] = act_elem(rd_data[j*W +: W], mode_q);
    end
  end

  // p1: activated row and its index land in the output FIFO.
  always_ff @(posedge clk) begin
    if (rd_en) row_p0 <= rd_addr;
    if (push) begin
      fifo_data[wr_ptr] <= act_p0;
      fifo_row[wr_ptr]  <= row_p0;
    end
  end

endmodule

// File: tb/tb_act_row_scheduler.sv
// Scoreboard bench for act_row_scheduler: reads push model rows, output handshakes pop and compare.
module tb_act_row_scheduler;

  localparam int ROWS = 10;
  localparam int COLS = 10;
  localparam int W    = 16;
  localparam int DW   = COLS * W;
  localparam int AW   = $clog2(ROWS);

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_row;
  logic [DW-1:0] out_data;

  typedef struct {
    logic [AW-1:0] row;
    logic [DW-1:0] data;
  } sb_t;

  sb_t           sb[$];
  sb_t           mon_h;
  sb_t           mon_e;
  logic [DW-1:0] src [ROWS];
  logic [DW-1:0] exp029;
  logic [1:0]    exp_mode;
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            start_cyc = 0;
  int            acc_cnt = 0;
  int            done_cnt = 0;
  int            exp_addr = 0;
  bit            timed = 0;
  bit            t029 = 0;
  bit            was_stalled = 0;

  act_row_scheduler #(.ROWS(ROWS), .COLS(COLS), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Source buffer: data valid only the cycle after rd_en, junk otherwise.
  always @(posedge clk) begin
    if (rd_en) rd_data <= src[rd_addr];
    else       rd_data <= {$urandom, $urandom, $urandom, $urandom, $urandom};
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_row(input logic [DW-1:0] x, input logic [1:0] m);
    logic [DW-1:0] y;
    logic [W-1:0]  e;
    int            xi;
    int            p;
    y = '0;
    for (int j = 0; j < COLS; j++) begin
      e  = x[j*W +: W];
      xi = int'($signed(e));
      p  = xi;
      if (xi < 0 && m == 2'd1)      p = 0;
      else if (xi < 0 && m == 2'd2) p = (xi * 13) >>> 7;
      y[j*W +: W] = p[W-1:0];
    end
    return y;
  endfunction

  task automatic fill_src();
    int v;
    for (int r = 0; r < ROWS; r++) begin
      for (int j = 0; j < COLS; j++) begin
        v = $urandom;
        src[r][j*W +: W] = v[W-1:0];
      end
    end
    src[1][0 +: W] = 16'h8000;
    src[1][W +: W] = 16'h7FFF;
    src[2][0 +: W] = 16'hFFFF;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (start && !busy) begin
        start_cyc = cyc + 1;
        exp_mode  = mode;
        exp_addr  = 0;
        acc_cnt   = 0;
      end
      if (was_stalled) chk("valid_held", DW'(out_valid), DW'(1));
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("out_valid_unexpected", DW'(out_valid), '0);
        end else begin
          mon_h = sb[0];
          chk("out_row", DW'(out_row), DW'(mon_h.row));
          chk("out_data", out_data, mon_h.data);
          if (out_ready) begin
            void'(sb.pop_front());
            acc_cnt++;
            if (timed) chk("row_cycle", DW'(cyc - start_cyc), DW'(2 + int'(mon_h.row)));
            if (t029 && mon_h.row == '0) chk("leaky_row0", out_data, exp029);
          end
        end
      end
      was_stalled = out_valid && !out_ready;
      if (rd_en) begin
        if (exp_addr < ROWS) begin
          chk("rd_addr", DW'(rd_addr), DW'(exp_addr));
          mon_e.row  = AW'(exp_addr);
          mon_e.data = model_row(src[exp_addr], exp_mode);
          sb.push_back(mon_e);
          exp_addr++;
        end else begin
          chk("rd_extra", DW'(rd_en), '0);
        end
      end
      if (busy) chk("occupancy_le2", DW'(sb.size() <= 2), DW'(1));
      if (done) begin
        done_cnt++;
        chk("done_rows", DW'(acc_cnt), DW'(ROWS));
        if (timed) chk("done_cycle", DW'(cyc - start_cyc), DW'(ROWS + 2));
      end
    end else begin
      was_stalled = 0;
    end
  end

  // pat: 0 ready held high, 1 ready low for 5 cycles from first valid, 2 ready toggling.
  task automatic run_job(input logic [1:0] m, input int pat, input bit restart);
    int d0;
    int seen;
    d0    = done_cnt;
    seen  = 0;
    timed = (pat == 0);
    @(posedge clk); #1;
    mode      = m;
    start     = 1'b1;
    out_ready = (pat == 0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 300 && done_cnt == d0; k++) begin
      case (pat)
        0: out_ready = 1'b1;
        1: begin
          if (out_valid || seen > 0) seen++;
          out_ready = (seen > 5);
        end
        default: out_ready = ~out_ready;
      endcase
      if (restart && k == 3) begin
        start = 1'b1;
        mode  = 2'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", DW'(done_cnt), DW'(d0 + 1));
    chk("sb_drained", DW'(sb.size()), '0);
    chk("idle_after", DW'({busy, done, out_valid}), '0);
    out_ready = 1'b0;
    timed     = 0;
  endtask

  initial begin
    int a [10];
    int b [10];
    int tmp;
    a = '{-128, -1, -32768, 32767, 0, 100, -10, -1000, 5, -129};
    b = '{-13, -1, -3328, 32767, 0, 100, -2, -102, 5, -14};
    rst       = 1'b0;
    start     = 1'b0;
    mode      = 2'd0;
    out_ready = 1'b0;
    fill_src();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", DW'({busy, done, rd_en, out_valid}), '0);
    chk("rst_rd_addr", DW'(rd_addr), '0);
    chk("rst_out_row", DW'(out_row), '0);
    chk("rst_out_data", out_data, '0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int j = 0; j < COLS; j++) begin
      tmp = a[j];
      src[0][j*W +: W] = tmp[W-1:0];
      tmp = b[j];
      exp029[j*W +: W] = tmp[W-1:0];
    end
    t029 = 1;
    run_job(2'd2, 0, 0);
    t029 = 0;

    fill_src();
    run_job(2'd1, 0, 0);
    fill_src();
    run_job(2'd0, 1, 0);
    fill_src();
    run_job(2'd2, 2, 0);
    fill_src();
    run_job(2'd2, 0, 1);

    fill_src();
    timed = 1;
    @(posedge clk); #1;
    mode      = 2'd0;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 100 && acc_cnt < 5; k++) begin
      @(posedge clk); #1;
    end
    chk("rows_before_rst", DW'(acc_cnt), DW'(5));
    rst = 1'b0;
    #1;
    chk("async_rst_ctrl", DW'({busy, done, rd_en, out_valid}), '0);
    chk("async_rst_addr", DW'({rd_addr, out_row}), '0);
    chk("async_rst_data", out_data, '0);
    sb.delete();
    timed = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("quiet_after_rst", DW'({busy, done, rd_en, out_valid}), '0);
    end
    fill_src();
    run_job(2'd0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/act_row_scheduler.md
ACT_ROW_SCHEDULER -- requirements
Module: act_row_scheduler

Parameters
REQ-001 SHALL have parameters: ROWS, default 10, matrix row count; COLS, default 10, elements per row; W, default 16, signed element width.

Interface
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-004 SHALL have port: start  in  1  one-cycle job request.
REQ-005 SHALL have port: mode  in  2  activation select, sampled with start: 0 bypass, 1 ReLU, 2 leaky ReLU, 3 treated as bypass.
REQ-006 SHALL have port: busy  out  1  high from accepted start until done.
REQ-007 SHALL have port: done  out  1  one-cycle pulse when the job completes.
REQ-008 SHALL have port: rd_en  out  1  source buffer row read strobe.
REQ-009 SHALL have port: rd_addr  out  clog2(ROWS)  row index being read.
REQ-010 SHALL have port: rd_data  in  COLS*W  row data, valid exactly one cycle after rd_en; element j at bits [j*W +: W].
REQ-011 SHALL have port: out_valid  out  1  output row available.
REQ-012 SHALL have port: out_ready  in  1  consumer accepts row when out_valid && out_ready.
REQ-013 SHALL have port: out_row  out  clog2(ROWS)  row index of out_data.
REQ-014 SHALL have port: out_data  out  COLS*W  activated row, same packing as rd_data.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> FINISH -> IDLE; IDLE->RUN on start; RUN->FINISH when ROWS rows accepted at output; FINISH->IDLE after one cycle.
REQ-016 SHALL ignore start while busy; mode latched only on an accepted start.
REQ-017 SHALL drive busy = 1 in RUN and FINISH; done = 1 only in FINISH.
REQ-018 SHALL contain a 2-entry output FIFO holding processed rows with their indices.
REQ-019 SHALL assert rd_en in RUN only when rows_issued < ROWS and fifo_count + reads_in_flight < 2; rd_addr increments 0..ROWS-1 in order, one per issued read.
REQ-020 SHALL write activated rd_data into FIFO the cycle after rd_en (combinational activation on rd_data, registered in FIFO).
REQ-021 SHALL sustain one row per cycle when out_ready is held high; first out_valid two cycles after start.
REQ-022 SHALL keep out_data/out_row stable while out_valid && !out_ready; out_valid not deasserted without acceptance.
REQ-023 SHALL handle simultaneous FIFO push and pop in one cycle with count unchanged.
REQ-024 SHALL apply per element, bypass: y = x; ReLU: y = (x < 0) ? 0 : x.
REQ-025 SHALL apply leaky: x >= 0 -> y = x; x < 0 -> y = (x*13) >>> 7, product in signed W+4 bits, arithmetic shift, truncated to W bits (0.1015625 slope, rounds toward -inf).
REQ-026 SHALL drive out_valid = 0 outside RUN; rows_issued and accepted counters cleared on entry to RUN.

Reset
REQ-027 SHALL on rst = 0 immediately force: state IDLE, busy 0, done 0, rd_en 0, rd_addr 0, out_valid 0, out_row 0, out_data 0, FIFO empty, counters 0, mode register 0.
REQ-028 SHALL abandon any job in progress on reset, with no done pulse and no further reads after rst returns high until a new start.

Verification
REQ-029 SHALL pass: mode 2, row 0 = {-128, -1, -32768, 32767, 0, 100, -10, -1000, 5, -129}, out_ready=1 -> row 0 out = {-13, -1, -3328, 32767, 0, 100, -2, -102, 5, -14}.
REQ-030 SHALL pass: mode 1, ROWS rows, out_ready=1 -> negatives become 0, rows 0..9 on consecutive cycles 2..11 after start, done at cycle 12.
REQ-031 SHALL pass: mode 0, out_ready low 5 cycles after first out_valid -> out_data/out_row held, at most 2 reads outstanding+buffered, no row lost or duplicated.
REQ-032 SHALL pass: out_ready toggling every cycle -> rows 0..9 delivered in order exactly once, single done pulse.
REQ-033 SHALL pass: start pulsed again mid-job with mode 1 -> ignored, current job completes with original mode.
REQ-034 SHALL pass: rst low after row 4 accepted -> all outputs 0 same cycle; new start then delivers rows 0..9 from row 0.
